// File: rtl/keypoint_pkg.sv
// keypoint_pkg
// Definitions shared by the SIFT keypoint front end: the keypoints detector
// and the keypoint_collector that follows it.
//   kp_state_t  - collector frame FSM encoding (IDLE between frames, RUN inside one)
//   N_DEFAULT / M_DEFAULT - default image rows / columns
//   coord_width - bits needed to address 0..extent-1
package keypoint_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } kp_state_t;

    localparam int N_DEFAULT = 450;
    localparam int M_DEFAULT = 600;

    // Width of a coordinate that must reach extent-1. The width is never
    // allowed to drop below one bit.
    function automatic int coord_width(input int extent);
        return (extent > 1) ? $clog2(extent) : 1;
    endfunction

endpackage

// File: rtl/kp_fifo.sv
// kp_fifo
// Synchronous first-word-fall-through FIFO with a registered head word.
// The FIFO can accept a push while it is full if the head is popped in the
// same cycle.
//   clk, rst    - clock, synchronous active-high reset
//   push        - request to write push_data
//   push_data   - word to write
//   pop_ready   - consumer takes the head when head_valid is also high
//   head_valid  - the FIFO holds at least one word
//   head_data   - oldest word; held steady until it is popped
//   full        - all DEPTH entries are occupied
//   accept      - this cycle's push is being written
module kp_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop_ready,
    output logic         head_valid,
    output logic [W-1:0] head_data,
    output logic         full,
    output logic         accept
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          do_pop;

    assign head_valid = (count != '0);
    assign full       = (count == (AW+1)'(DEPTH));
    assign do_pop     = head_valid & pop_ready;
    assign accept     = push & (~full | do_pop);

    // Storage array. It has no reset because stale words are never read.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and the registered head word. On a pop the head
    // is refilled from the next stored entry. If the FIFO would otherwise
    // be empty, the word being pushed in that cycle becomes the new head.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            head_data <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({accept, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (do_pop) begin
                if (count > (AW+1)'(1)) begin
                    head_data <= mem[rd_ptr + AW'(1)];
                end else if (accept) begin
                    head_data <= push_data;
                end
            end else if (!head_valid && accept) begin
                head_data <= push_data;
            end
        end
    end

endmodule

// File: rtl/keypoint_collector.sv
// keypoint_collector
// Converts the keypoints detector's raster-ordered interior flag stream
// into full-image (x, y) coordinates. It buffers the coordinates in a
// FIFO, reports each frame's keypoint count and flags dropped keypoints.
//   clk, rst        - clock, synchronous active-high reset
//   din_valid, din  - flag stream; any nonzero din is a keypoint
//   kp_valid/kp_ready, kp_x/kp_y - coordinate output handshake
//   frame_done      - one-cycle pulse after the last interior pixel
//   kp_count        - keypoints accepted in the last completed frame
//   overflow        - sticky; a keypoint was dropped in this frame
module keypoint_collector
    import keypoint_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int M     = M_DEFAULT,
    parameter int XW    = 10,
    parameter int YW    = 10,
    parameter int CW    = 19,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din_valid,
    input  logic [7:0]    din,
    output logic          kp_valid,
    input  logic          kp_ready,
    output logic [XW-1:0] kp_x,
    output logic [YW-1:0] kp_y,
    output logic          frame_done,
    output logic [CW-1:0] kp_count,
    output logic          overflow
);

    kp_state_t       state;
    kp_state_t       state_next;
    logic [XW-1:0]   col;
    logic [YW-1:0]   row;
    logic [CW-1:0]   frame_cnt;
    logic            is_kp;
    logic            col_last;
    logic            last_beat;
    logic            start_frame;
    logic            accept;
    logic            drop;
    logic            fifo_full;
    logic [XW+YW-1:0] push_data;
    logic [XW+YW-1:0] head_data;

    assign is_kp     = din_valid && (din != 8'h00);
    assign col_last  = (col == XW'(M-3));
    assign last_beat = din_valid && col_last && (row == YW'(N-3));
    assign drop      = is_kp & ~accept;

    // The one-pixel border is restored here. Interior pixel (0,0) is
    // image pixel (1,1).
    assign push_data = {row + YW'(1), col + XW'(1)};
    assign kp_x      = head_data[XW-1:0];
    assign kp_y      = head_data[XW+YW-1:XW];

    kp_fifo #(
        .W     (XW+YW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (is_kp),
        .push_data  (push_data),
        .pop_ready  (kp_ready),
        .head_valid (kp_valid),
        .head_data  (head_data),
        .full       (fifo_full),
        .accept     (accept)
    );

    // Frame FSM next state. The first valid beat in IDLE starts a frame
    // and is processed like any other beat. The last-pixel beat returns
    // the FSM to IDLE.
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        case (state)
            IDLE: begin
                if (din_valid) begin
                    start_frame = 1'b1;
                    state_next  = last_beat ? IDLE : RUN;
                end
            end
            RUN: begin
                if (last_beat) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, position counters, frame count and overflow.
    // The counters wrap to zero on the last pixel, so IDLE always starts
    // the next frame at (0,0). kp_count latches the running count plus
    // the final beat's keypoint on the edge that raises frame_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            frame_cnt  <= '0;
            kp_count   <= '0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            frame_done <= last_beat;

            if (din_valid) begin
                if (col_last) begin
                    col <= '0;
                    row <= (row == YW'(N-3)) ? '0 : row + YW'(1);
                end else begin
                    col <= col + XW'(1);
                end
            end

            if (last_beat) begin
                frame_cnt <= '0;
                kp_count  <= frame_cnt + CW'(accept);
            end else if (accept) begin
                frame_cnt <= frame_cnt + CW'(1);
            end

            if (start_frame) begin
                overflow <= drop;
            end else if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_keypoint_collector.sv
// tb_keypoint_collector
// Directed bench for keypoint_collector on a 5x6 image (3x4 interior) with
// a 4-entry FIFO. Every popped coordinate is captured on the falling edge
// and compared against hand-computed lists.
module tb_keypoint_collector;

    localparam int N     = 5;
    localparam int M     = 6;
    localparam int XW    = 10;
    localparam int YW    = 10;
    localparam int CW    = 19;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          din_valid;
    logic [7:0]    din;
    logic          kp_valid;
    logic          kp_ready;
    logic [XW-1:0] kp_x;
    logic [YW-1:0] kp_y;
    logic          frame_done;
    logic [CW-1:0] kp_count;
    logic          overflow;

    int compared   = 0;
    int mismatched = 0;
    int fd_pulses  = 0;
    int got_x[$];
    int got_y[$];
    int exp_x[$];
    int exp_y[$];

    keypoint_collector #(
        .N(N), .M(M), .XW(XW), .YW(YW), .CW(CW), .DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din        (din),
        .kp_valid   (kp_valid),
        .kp_ready   (kp_ready),
        .kp_x       (kp_x),
        .kp_y       (kp_y),
        .frame_done (frame_done),
        .kp_count   (kp_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Capture every pop and every frame_done pulse on the falling edge,
    // well away from the rising edge where they take effect.
    always @(negedge clk) begin
        if (!rst && kp_valid && kp_ready) begin
            got_x.push_back(int'(kp_x));
            got_y.push_back(int'(kp_y));
        end
        if (frame_done) begin
            fd_pulses++;
        end
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // One input beat. Inputs change 1 ns after a rising edge, and the task
    // returns 1 ns after the edge that samples the beat.
    task automatic applyStimulus(input logic v, input logic [7:0] d);
        din_valid = v;
        din       = d;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din       = 8'h00;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 8'h00);
    endtask

    // A full 12-pixel frame; pattern bit k flags raster beat k. With
    // max_gap > 0, random idle cycles are inserted before each beat.
    task automatic runFrame(input logic [11:0] pattern, input int max_gap,
                            input bit check_ovf_clear);
        for (int k = 0; k < 12; k++) begin
            if (max_gap > 0) idleCycles(int'($urandom_range(0, max_gap)));
            applyStimulus(1'b1, pattern[k] ? 8'hFF : 8'h00);
            if (k == 0 && check_ovf_clear) checkOutput("ovf_clear_first_beat", int'(overflow), 0);
        end
    endtask

    task automatic expectCoord(input int x, input int y);
        exp_x.push_back(x);
        exp_y.push_back(y);
    endtask

    task automatic clearQueues();
        got_x.delete(); got_y.delete(); exp_x.delete(); exp_y.delete();
    endtask

    task automatic checkQueue(input string tag);
        int n;
        checkOutput({tag, "_len"}, got_x.size(), exp_x.size());
        n = (got_x.size() < exp_x.size()) ? got_x.size() : exp_x.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_x[%0d]", tag, i), got_x[i], exp_x[i]);
            checkOutput($sformatf("%s_y[%0d]", tag, i), got_y[i], exp_y[i]);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_kp_valid"},   int'(kp_valid),   0);
        checkOutput({tag, "_kp_x"},       int'(kp_x),       0);
        checkOutput({tag, "_kp_y"},       int'(kp_y),       0);
        checkOutput({tag, "_frame_done"}, int'(frame_done), 0);
        checkOutput({tag, "_kp_count"},   int'(kp_count),   0);
        checkOutput({tag, "_overflow"},   int'(overflow),   0);
    endtask

    initial begin
        rst       = 1'b1;
        din_valid = 1'b0;
        din       = 8'h00;
        kp_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        rst = 1'b0;

        // Single keypoint at beat 6 -> (2,2)
        $display("[TB] single keypoint");
        clearQueues();
        kp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b1, (k == 5) ? 8'hFF : 8'h00);
            if (k == 5) begin
                checkOutput("single_valid", int'(kp_valid), 1);
                checkOutput("single_x", int'(kp_x), 2);
                checkOutput("single_y", int'(kp_y), 2);
            end
            if (k == 6) checkOutput("single_popped", int'(kp_valid), 0);
            if (k == 10) checkOutput("single_fd_early", int'(frame_done), 0);
        end
        checkOutput("single_frame_done", int'(frame_done), 1);
        checkOutput("single_kp_count", int'(kp_count), 1);
        idleCycles(1);
        checkOutput("single_fd_one_cycle", int'(frame_done), 0);
        expectCoord(2, 2);
        checkQueue("single");

        // Every pixel a keypoint, consumer always ready
        $display("[TB] all-keypoint frame");
        clearQueues();
        runFrame(12'hFFF, 0, 1'b0);
        checkOutput("all_kp_count", int'(kp_count), 12);
        checkOutput("all_overflow", int'(overflow), 0);
        idleCycles(2);
        for (int k = 0; k < 12; k++) expectCoord(k % 4 + 1, k / 4 + 1);
        checkQueue("all");

        // Backpressure: six keypoints into four slots
        $display("[TB] backpressure");
        clearQueues();
        kp_ready = 1'b0;
        runFrame(12'h03F, 0, 1'b0);
        checkOutput("bp_overflow", int'(overflow), 1);
        checkOutput("bp_kp_count", int'(kp_count), 4);
        for (int i = 0; i < 3; i++) begin
            idleCycles(1);
            checkOutput("bp_stall_valid", int'(kp_valid), 1);
            checkOutput("bp_stall_x", int'(kp_x), 1);
            checkOutput("bp_stall_y", int'(kp_y), 1);
        end
        kp_ready = 1'b1;
        idleCycles(6);
        checkOutput("bp_drained", int'(kp_valid), 0);
        checkOutput("bp_overflow_sticky", int'(overflow), 1);
        expectCoord(1, 1); expectCoord(2, 1); expectCoord(3, 1); expectCoord(4, 1);
        checkQueue("bp");

        // Full FIFO with a simultaneous pop and push
        $display("[TB] full with pop");
        clearQueues();
        kp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 8'hFF);
            if (k == 0) checkOutput("full_ovf_cleared", int'(overflow), 0);
        end
        kp_ready = 1'b1;
        applyStimulus(1'b1, 8'hFF);
        kp_ready = 1'b0;
        checkOutput("full_pop_no_ovf", int'(overflow), 0);
        for (int k = 5; k < 12; k++) applyStimulus(1'b1, 8'h00);
        checkOutput("full_kp_count", int'(kp_count), 5);
        checkOutput("full_overflow", int'(overflow), 0);
        kp_ready = 1'b1;
        idleCycles(6);
        expectCoord(1, 1); expectCoord(2, 1); expectCoord(3, 1); expectCoord(4, 1);
        expectCoord(1, 2);
        checkQueue("full");

        // Gapped back-to-back frames. Frame 1 overflows with ready low,
        // and its entries drain during frame 2.
        $display("[TB] gapped frames");
        clearQueues();
        kp_ready = 1'b0;
        runFrame(12'h8A5, 2, 1'b0);
        checkOutput("gap1_kp_count", int'(kp_count), 4);
        checkOutput("gap1_overflow", int'(overflow), 1);
        kp_ready = 1'b1;
        runFrame(12'h442, 2, 1'b1);
        checkOutput("gap2_kp_count", int'(kp_count), 3);
        checkOutput("gap2_overflow", int'(overflow), 0);
        idleCycles(4);
        expectCoord(1, 1); expectCoord(3, 1); expectCoord(2, 2); expectCoord(4, 2);
        expectCoord(2, 1); expectCoord(3, 2); expectCoord(3, 3);
        checkQueue("gap");

        // Reset in the middle of a frame
        $display("[TB] mid-frame reset");
        clearQueues();
        kp_ready = 1'b0;
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 8'hFF);
        checkOutput("mid_pre_overflow", int'(overflow), 1);
        rst = 1'b1;
        idleCycles(1);
        checkResetState("mid_reset");
        rst = 1'b0;
        kp_ready = 1'b1;
        applyStimulus(1'b1, 8'hFF);
        checkOutput("mid_first_valid", int'(kp_valid), 1);
        checkOutput("mid_first_x", int'(kp_x), 1);
        checkOutput("mid_first_y", int'(kp_y), 1);
        for (int k = 1; k < 12; k++) applyStimulus(1'b1, 8'h00);
        checkOutput("mid_kp_count", int'(kp_count), 1);
        idleCycles(2);
        expectCoord(1, 1);
        checkQueue("mid");

        checkOutput("frame_done_pulses", fd_pulses, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
